// File: rtl/pipe_stage_chain.sv
// In-order pipeline latch chain with valid-qualified stall, flush and
// saturating performance counters.
module pipe_stage_chain #(
  parameter int W       = 32,
  parameter int NSTAGES = 5,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 in_v,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  input  logic [NSTAGES-1:0]   stall_req,
  input  logic [NSTAGES-1:0]   flush_req,
  output logic [NSTAGES-1:0]   stage_v,
  output logic [NSTAGES*W-1:0] stage_data,
  output logic                 out_v,
  output logic [W-1:0]         out_data,
  output logic [CNTW-1:0]      stall_cnt,
  output logic [CNTW-1:0]      flush_cnt,
  output logic [CNTW-1:0]      retire_cnt
);

  logic [NSTAGES-1:0] v_q;
  logic [W-1:0]       data_q [NSTAGES];

  logic [NSTAGES-1:0] eff_stall;
  logic [NSTAGES-1:0] eff_flush;
  logic [NSTAGES-1:0] hold;
  logic [NSTAGES-1:0] squash;
  logic [NSTAGES-1:0] v_nxt;
  logic               any_stall;
  logic               any_flush;

  // Qualify requests with stage validity; only the oldest flush counts.
  always_comb begin
    logic found;
    found     = 1'b0;
    eff_stall = stall_req & v_q;
    eff_flush = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      eff_flush[k] = flush_req[k] & v_q[k] & ~found;
      found        = found | eff_flush[k];
    end
  end

  // Hold propagates from a stalled stage to all younger stages;
  // squash marks every stage younger than the flushing one.
  always_comb begin
    logic hacc;
    logic sacc;
    hacc   = 1'b0;
    sacc   = 1'b0;
    hold   = '0;
    squash = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      hacc      = hacc | eff_stall[k];
      hold[k]   = hacc;
      squash[k] = sacc;
      sacc      = sacc | eff_flush[k];
    end
  end

  assign any_stall = |eff_stall;
  assign any_flush = |eff_flush;

  // Next valid bits: squash beats hold, hold beats advance.
  always_comb begin
    v_nxt = '0;
    if (squash[0])
      v_nxt[0] = 1'b0;
    else if (hold[0])
      v_nxt[0] = v_q[0];
    else
      v_nxt[0] = in_v;
    for (int k = 1; k < NSTAGES; k++) begin
      if (squash[k])
        v_nxt[k] = 1'b0;
      else if (hold[k])
        v_nxt[k] = v_q[k];
      else
        v_nxt[k] = v_q[k-1] & ~eff_stall[k-1];
    end
  end

  // Stage valid register.
  always_ff @(posedge clk) begin
    if (r)
      v_q <= '0;
    else
      v_q <= v_nxt;
  end

  // Stage payload registers; payload loads whenever the stage is not held.
  always_ff @(posedge clk) begin
    if (r) begin
      for (int k = 0; k < NSTAGES; k++)
        data_q[k] <= '0;
    end else begin
      if (!hold[0])
        data_q[0] <= in_data;
      for (int k = 1; k < NSTAGES; k++)
        if (!hold[k])
          data_q[k] <= data_q[k-1];
    end
  end

  // Saturating stall / flush / retire counters.
  always_ff @(posedge clk) begin
    if (r) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (any_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (any_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
      if (out_v && retire_cnt != '1)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

  // Flatten payloads for observation by stage logic.
  always_comb begin
    stage_data = '0;
    for (int k = 0; k < NSTAGES; k++)
      stage_data[k*W +: W] = data_q[k];
  end

  assign stage_v  = v_q;
  assign in_ready = ~r & ~hold[0] & ~any_flush;
  assign out_v    = ~r & v_q[NSTAGES-1] & ~eff_stall[NSTAGES-1];
  assign out_data = data_q[NSTAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed table-driven bench for pipe_stage_chain (W=32, NSTAGES=5, CNTW=16).
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        r;
  logic        in_v;
  logic [31:0] in_data;
  logic        in_ready;
  logic [4:0]  stall_req;
  logic [4:0]  flush_req;
  logic [4:0]  stage_v;
  logic [159:0] stage_data;
  logic        out_v;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] retire_cnt;

  int total = 0;
  int passed = 0;

  pipe_stage_chain #(.W(32), .NSTAGES(5), .CNTW(16)) dut (
    .clk(clk), .r(r), .in_v(in_v), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
    .stage_v(stage_v), .stage_data(stage_data), .out_v(out_v),
    .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        ir;
    logic [4:0]  sv;
    logic        ov;
    logic [31:0] od;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [15:0] rc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic iv, input logic [31:0] id,
                     input logic [4:0] st, input logic [4:0] fl,
                     input logic ir, input logic [4:0] sv,
                     input logic ov, input logic [31:0] od,
                     input logic [15:0] sc, input logic [15:0] fc,
                     input logic [15:0] rc);
    vec_t t;
    t.iv = iv; t.id = id; t.st = st; t.fl = fl; t.ir = ir; t.sv = sv;
    t.ov = ov; t.od = od; t.sc = sc; t.fc = fc; t.rc = rc;
    tbl.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r = 1'b1; in_v = 1'b1; in_data = 32'hdead;
    stall_req = '0; flush_req = '0;
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
    chk("rst_out_v", 64'(out_v), 64'(1'b0));
    chk("rst_stage_v", 64'(stage_v), 64'(5'b0));
    chk("rst_cnt", 64'({stall_cnt, flush_cnt, retire_cnt}), 64'(48'd0));
    chk("rst_data", 64'(stage_data == '0), 64'(1'b1));
    r = 1'b0; in_v = 1'b0;

    // Stream 0x11..0x55 with no stalls.
    add(1, 32'h11, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 0);
    add(1, 32'h22, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 0);
    add(1, 32'h33, 0, 0, 1, 5'b00011, 0, 0, 0, 0, 0);
    add(1, 32'h44, 0, 0, 1, 5'b00111, 0, 0, 0, 0, 0);
    add(1, 32'h55, 0, 0, 1, 5'b01111, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5'b11111, 1, 32'h11, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5'b11110, 1, 32'h22, 0, 0, 1);
    add(0, 0, 0, 0, 1, 5'b11100, 1, 32'h33, 0, 0, 2);
    add(0, 0, 0, 0, 1, 5'b11000, 1, 32'h44, 0, 0, 3);
    add(0, 0, 0, 0, 1, 5'b10000, 1, 32'h55, 0, 0, 4);
    // Fill, then stall stage 2 for three cycles.
    add(1, 32'hA1, 0, 0, 1, 5'b00000, 0, 0, 0, 0, 5);
    add(1, 32'hA2, 0, 0, 1, 5'b00001, 0, 0, 0, 0, 5);
    add(1, 32'hA3, 0, 0, 1, 5'b00011, 0, 0, 0, 0, 5);
    add(1, 32'hA4, 0, 0, 1, 5'b00111, 0, 0, 0, 0, 5);
    add(1, 32'hA5, 0, 0, 1, 5'b01111, 0, 0, 0, 0, 5);
    add(1, 32'hA6, 5'b00100, 0, 0, 5'b11111, 1, 32'hA1, 0, 0, 5);
    add(1, 32'hA6, 5'b00100, 0, 0, 5'b10111, 1, 32'hA2, 1, 0, 6);
    add(1, 32'hA6, 5'b00100, 0, 0, 5'b00111, 0, 0, 2, 0, 7);
    add(1, 32'hA6, 0, 0, 1, 5'b00111, 0, 0, 3, 0, 7);
    add(0, 0, 0, 0, 1, 5'b01111, 0, 0, 3, 0, 7);
    add(0, 0, 0, 0, 1, 5'b11110, 1, 32'hA3, 3, 0, 7);
    add(0, 0, 0, 0, 1, 5'b11100, 1, 32'hA4, 3, 0, 8);
    add(0, 0, 0, 0, 1, 5'b11000, 1, 32'hA5, 3, 0, 9);
    add(0, 0, 0, 0, 1, 5'b10000, 1, 32'hA6, 3, 0, 10);
    // Stall request from an invalid stage is ignored.
    add(1, 32'hB1, 5'b00010, 0, 1, 5'b00000, 0, 0, 3, 0, 11);
    add(1, 32'hB2, 0, 0, 1, 5'b00001, 0, 0, 3, 0, 11);
    add(1, 32'hB3, 0, 0, 1, 5'b00011, 0, 0, 3, 0, 11);
    add(1, 32'hB4, 0, 0, 1, 5'b00111, 0, 0, 3, 0, 11);
    add(1, 32'hB5, 0, 0, 1, 5'b01111, 0, 0, 3, 0, 11);
    // Flush from stage 3 on a full pipe.
    add(1, 32'hB6, 0, 5'b01000, 0, 5'b11111, 1, 32'hB1, 3, 0, 11);
    add(0, 0, 0, 0, 1, 5'b11000, 1, 32'hB2, 3, 1, 12);
    add(0, 0, 0, 0, 1, 5'b10000, 1, 32'hB3, 3, 1, 13);
    // Two flushes plus stall on the older flusher.
    add(1, 32'hC1, 0, 0, 1, 5'b00000, 0, 0, 3, 1, 14);
    add(1, 32'hC2, 0, 0, 1, 5'b00001, 0, 0, 3, 1, 14);
    add(1, 32'hC3, 0, 0, 1, 5'b00011, 0, 0, 3, 1, 14);
    add(1, 32'hC4, 0, 0, 1, 5'b00111, 0, 0, 3, 1, 14);
    add(1, 32'hC5, 0, 0, 1, 5'b01111, 0, 0, 3, 1, 14);
    add(1, 32'hC6, 5'b01000, 5'b01010, 0, 5'b11111, 1, 32'hC1, 3, 1, 14);
    add(0, 0, 0, 0, 1, 5'b01000, 0, 0, 4, 2, 15);
    add(0, 0, 0, 0, 1, 5'b10000, 1, 32'hC2, 4, 2, 15);
    add(0, 0, 0, 0, 1, 5'b00000, 0, 0, 4, 2, 16);

    foreach (tbl[i]) begin
      in_v = tbl[i].iv; in_data = tbl[i].id;
      stall_req = tbl[i].st; flush_req = tbl[i].fl;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      chk($sformatf("v%0d_stage_v", i), 64'(stage_v), 64'(tbl[i].sv));
      chk($sformatf("v%0d_out_v", i), 64'(out_v), 64'(tbl[i].ov));
      if (tbl[i].ov)
        chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(tbl[i].od));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].sc));
      chk($sformatf("v%0d_flush_cnt", i), 64'(flush_cnt), 64'(tbl[i].fc));
      chk($sformatf("v%0d_retire_cnt", i), 64'(retire_cnt), 64'(tbl[i].rc));
      step();
    end
    in_v = 0; stall_req = '0; flush_req = '0;

    // Stream until retire_cnt reaches 0xFFFE, then past saturation.
    in_v = 1; in_data = 32'h77;
    for (int k = 0; k < 65523; k++) step();
    chk("sat_fffe", 64'(retire_cnt), 64'(16'hFFFE));
    step();
    chk("sat_ffff", 64'(retire_cnt), 64'(16'hFFFF));
    step(); step();
    chk("sat_hold", 64'(retire_cnt), 64'(16'hFFFF));
    in_v = 0;
    for (int k = 0; k < 6; k++) step();
    chk("sat_drain", 64'(retire_cnt), 64'(16'hFFFF));
    chk("sat_empty", 64'(stage_v), 64'(5'b0));

    // Fill, stall stage 2, then reset in the middle of the stall.
    for (int k = 0; k < 5; k++) begin
      in_v = 1; in_data = 32'hD1 + 32'(k);
      step();
    end
    in_v = 0; stall_req = 5'b00100;
    step(); step();
    chk("pre_rst_stall_cnt", 64'(stall_cnt), 64'(16'd6));
    chk("pre_rst_stage_v", 64'(stage_v), 64'(5'b00111));
    r = 1; in_v = 1;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1'b0));
    step();
    chk("post_rst_stage_v", 64'(stage_v), 64'(5'b0));
    chk("post_rst_cnt", 64'({stall_cnt, flush_cnt, retire_cnt}), 64'(48'd0));
    chk("post_rst_data", 64'(stage_data == '0), 64'(1'b1));
    chk("post_rst_out_v", 64'(out_v), 64'(1'b0));
    r = 0; in_v = 0; stall_req = '0;
    step();
    chk("idle_stage_v", 64'(stage_v), 64'(5'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised in-order pipeline latch chain: NSTAGES stage registers, each carrying a W-bit payload plus a valid bit.
- Generalises the per-stage enable/valid latching of the pipeline top level into one reusable block.
- Adds valid-qualified per-stage stall with bubble insertion, per-stage flush (squash of younger stages), and saturating performance counters.
- Sits between fetch and writeback; stage-specific logic reads stage payloads and feeds back stall/flush requests.

Parameters:
- W, 32, payload width per stage.
- NSTAGES, 5, number of stage registers; legal range 2..16. Index 0 is the youngest stage; index NSTAGES-1 is the oldest (last) stage.
- CNTW, 16, width of each performance counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- r  input  1  reset, synchronous, active-high.
- in_v  input  1  new instruction offered to stage 0.
- in_data  input  W  payload for stage 0.
- in_ready  output  1  stage 0 loads this cycle; in_v & in_ready means the input is accepted.
- stall_req  input  NSTAGES  bit k: stage k cannot complete this cycle.
- flush_req  input  NSTAGES  bit k: stage k resolves a redirect; squash all younger stages.
- stage_v  output  NSTAGES  valid bit of each stage register.
- stage_data  output  NSTAGES*W  payloads, stage k at bits [k*W +: W].
- out_v  output  1  oldest stage completes this cycle.
- out_data  output  W  payload of oldest stage.
- stall_cnt  output  CNTW  cycles with any effective stall.
- flush_cnt  output  CNTW  effective flush events.
- retire_cnt  output  CNTW  out_v cycles.

Behaviour:
- Reset (r=1 at posedge): all stage_v=0, all stage_data=0, all counters=0. Reset overrides every other event, including mid-stall and mid-flush. While r=1, in_ready=0 and out_v=0.
- eff_stall[k] = stall_req[k] & stage_v[k]. Stall requests from invalid stages are ignored.
- eff_flush[k] = flush_req[k] & stage_v[k] & no eff_flush[j] for any j>k. If several stages request a flush, only the oldest flushing stage counts.
- hold[k] = OR of eff_stall[j] for j>=k. A stage register keeps its value when any stage at the same index or older is stalled.
- Next state of stage k>0, when not held:
  - valid = stage_v[k-1] & !eff_stall[k-1].
  - data = stage_data[k-1].
  - When stage k-1 is stalled, stage k receives a bubble (valid=0); its data still loads and is don't-care.
- Stage 0 when not held: valid = in_v, data = in_data.
- in_ready = !hold[0] & no eff_flush in any stage.
- Flush: when eff_flush[f], every stage k<f gets valid=0 next cycle, whether or not it is held. This forces bubbles into the squashed stages and drops the input. Stage f and older stages follow normal hold/advance rules. Flush takes priority over stall for the squashed stages.
- out_v = stage_v[NSTAGES-1] & !eff_stall[NSTAGES-1]. out_data = stage_data[NSTAGES-1] (combinational).
- Latency: an accepted input appears at out_v exactly NSTAGES cycles after acceptance when no stalls occur.
- Counters are saturating at 2^CNTW-1 and never wrap:
  - stall_cnt += 1 on each cycle where any eff_stall is set.
  - flush_cnt += 1 on each cycle where any eff_flush is set (at most +1 per cycle).
  - retire_cnt += 1 on each cycle where out_v=1.
- Simultaneous stall and flush on the same stage: that stage holds and younger stages are squashed. The stage's flush_req stays effective while it holds and its request stays asserted, so flush_cnt increments each such cycle.
- Payloads move without modification.

Test Plan:
- Reset, then in_v=1 with in_data=0x11,0x22,0x33,0x44,0x55 on consecutive cycles, no stalls -> out_v first high 5 cycles after 0x11 is accepted; outputs 0x11..0x55 in order; retire_cnt=5.
- Fill the pipe, then stall_req[2]=1 for 3 cycles -> stages 0..2 frozen and in_ready=0; stage 3 receives 3 bubbles; stall_cnt=3; no payload lost or duplicated at the output.
- stall_req[1]=1 while stage_v[1]=0 -> no hold, in_ready=1, stall_cnt unchanged.
- Full pipe, flush_req[3]=1 for one cycle -> stage_v[2:0]=000 next cycle; stage 3 payload advances to stage 4; same-cycle input dropped (in_ready=0); flush_cnt=1.
- flush_req[1] and flush_req[3] asserted together, with stall_req[3]=1 -> only stage 3's flush is effective: stages 0..2 squashed, stage 3 held, flush_cnt +1.
- Force retire_cnt to 0xFFFE with CNTW=16 and retire 3 items -> retire_cnt saturates at 0xFFFF. Assert r in the middle of a stall -> all stage_v=0 and all counters=0 next cycle.
